instr_fetch_unit: RTL and testbench

- Supplier side of the CPU instruction interface: owns the fetch PC, issues word reads to instruction memory, buffers returned words and presents them to the CPU core over a valid/ready handshake.
- Handles branch/jump redirects from the core by flushing buffered words and discarding responses already in flight.
- Sits between the instruction memory port and the core's instr input.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch front end. Owns the fetch PC, issues word
//                reads to instruction memory, buffers in-order responses in a
//                small FIFO and hands them to the core over valid/ready.
//                Redirects flush the buffer and discard in-flight responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q,   rsp_pc_d;
  logic [C_CNT_W-1:0] live_q,     live_d;
  logic [C_CNT_W-1:0] drop_q,     drop_d;
  logic [C_OCC_W-1:0] occ_q,      occ_d;
  logic [C_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;

  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q   [FIFO_DEPTH];

  logic [31:0] in_flight;
  logic [31:0] committed;
  logic        req_fire;
  logic        rsp_keep;
  logic        rsp_drop;
  logic        pop;
  logic [31:0] redirect_base;
  logic        unused_redirect_lsbs;

  // Low address bits of a redirect target are meaningless for word fetches.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_base        = {redirect_pc[31:2], 2'b00};

  // Credit check uses registered counters only, so the request never depends
  // on imem_req_ready. occ+live bounds the FIFO so kept responses always fit.
  assign in_flight      = 32'(live_q) + 32'(drop_q);
  assign committed      = 32'(occ_q) + 32'(live_q);
  assign imem_req_valid = rst && !redirect_valid &&
                          (in_flight < 32'(MAX_OUTSTANDING)) &&
                          (committed < 32'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  // Responses return in order, so pending drops always belong to the oldest.
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (occ_q != '0);
  assign instr       = instr_valid ? data_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : 32'h0;

  // Next-state computation for PCs, in-flight counters and FIFO bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response arriving now is
      // one of those stale words and is consumed here.
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_d     = drop_q + live_q - (imem_rsp_valid ? C_CNT_W'(1) : C_CNT_W'(0));
      live_d     = '0;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - C_CNT_W'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      live_d = live_q + (req_fire ? C_CNT_W'(1) : C_CNT_W'(0))
                      - (rsp_keep ? C_CNT_W'(1) : C_CNT_W'(0));
      occ_d  = occ_q + (rsp_keep ? C_OCC_W'(1) : C_OCC_W'(0))
                     - (pop      ? C_OCC_W'(1) : C_OCC_W'(0));
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are only visible through occ, so no reset needed.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      data_q[wr_ptr_q] <= imem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with an in-order
//                variable-latency memory model and a queue-based reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch_unit #(
    .RESET_PC       (RPC),
    .FIFO_DEPTH     (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: accepted requests answered in order after 'lat' cycles.
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t pend[$];
  int    cyc = 0;
  int    lat = 1;
  int    last_due = -100;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference: ordered list of outstanding requests with a keep flag, and
  // the instruction buffer as a queue of {word, pc}.
  typedef struct { logic [31:0] pc; bit keep; } out_t;
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  out_t        mout[$];
  ent_t        mfifo[$];
  logic [31:0] mpc;

  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_i, s_ipc;
  logic [31:0] got[$];

  task automatic step(input bit ir, input bit rdy, input bit redir, input logic [31:0] rpc);
    int   kept;
    int   d;
    bit   erv, eiv;
    logic [31:0] ei, eipc;
    out_t o;
    @(negedge clk);
    instr_ready    = ir;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_iv = instr_valid;    s_i = instr; s_ipc = instr_pc;
    kept = 0;
    foreach (mout[k]) if (mout[k].keep) kept++;
    erv  = !redir && (mout.size() < MAXO) && ((mfifo.size() + kept) < DEPTH);
    eiv  = (mfifo.size() != 0);
    ei   = eiv ? mfifo[0].d  : 32'h0;
    eipc = eiv ? mfifo[0].pc : 32'h0;
    chk("imem_req_valid", s_rv, erv);
    chk("imem_req_addr", s_addr, mpc);
    chk("instr_valid", s_iv, eiv);
    chk("instr", s_i, ei);
    chk("instr_pc", s_ipc, eipc);
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{d, imem_req_addr});
      chk("outstanding_limit", 32'(pend.size() <= MAXO), 32'd1);
    end
    if (eiv && ir && !redir) void'(mfifo.pop_front());
    if (imem_rsp_valid) begin
      if (mout.size() == 0) chk("response_expected", 32'd0, 32'd1);
      else begin
        o = mout.pop_front();
        if (o.keep && !redir) mfifo.push_back('{imem_rsp_data, o.pc});
      end
    end
    if (redir) begin
      mfifo.delete();
      foreach (mout[k]) mout[k].keep = 1'b0;
      mpc = {rpc[31:2], 2'b00};
    end else if (erv && rdy) begin
      mout.push_back('{mpc, 1'b1});
      mpc = mpc + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    instr_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pend.delete(); mout.delete(); mfifo.delete();
    mpc = RPC; last_due = -100;
    #1;
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_instr_valid", instr_valid, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RPC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Gather n delivered PCs with the core always ready, bounded by a budget.
  task automatic collect(input int n, input int budget);
    got.delete();
    while (got.size() < n && budget > 0) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_iv) got.push_back(s_ipc);
      budget--;
    end
    chk("collect_count", got.size(), n);
    while (got.size() < n) got.push_back(32'hDEAD_BEEF);
  endtask

  typedef struct { bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc; } vec_t;
  vec_t tbl[7];

  initial begin
    bit found;
    tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
    tbl[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

    // Zero-wait memory startup sequence.
    lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].ir, 1'b1, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req_valid", i), s_rv, tbl[i].rv);
      chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), s_iv, tbl[i].iv);
      chk($sformatf("tbl%0d_instr_pc", i), s_ipc, tbl[i].ipc);
      if (tbl[i].iv) chk($sformatf("tbl%0d_instr", i), s_i, memfn(tbl[i].ipc));
    end
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Core stalls: buffer fills, requests stop, then drains in order.
    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_instr_valid", s_iv, 32'd1);
    chk("stall_req_valid", s_rv, 32'd0);
    collect(8, 40);
    for (int i = 1; i < 8; i++) chk($sformatf("drain_seq%0d", i), got[i], got[i-1] + 32'd4);

    // Three-cycle memory: in-flight cap reached right after reset.
    lat = 3;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("lat3_req_valid_cap", s_rv, 32'd0);
    chk("lat3_inflight", pend.size(), 32'd2);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_1002);
    chk("redir_req_valid", s_rv, 32'd0);
    collect(3, 40);
    chk("redir_first_pc", got[0], 32'h0000_1000);
    chk("redir_second_pc", got[1], 32'h0000_1004);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    do_reset();
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && mfifo.size() > 0) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("coincide_found", found, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    collect(3, 40);
    chk("coincide_pc0", got[0], 32'h0000_2000);
    chk("coincide_pc1", got[1], 32'h0000_2004);
    chk("coincide_pc2", got[2], 32'h0000_2008);

    // Address wrap at the top of memory.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    collect(3, 40);
    chk("wrap_pc0", got[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", got[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", got[2], 32'h0000_0000);

    // Random traffic against the reference, with an async reset mid-stream.
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
           ($urandom % 2) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom % 16)));
    end
    @(posedge clk);
    #2;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 4);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
